param_logic_core: RTL

PARAM_LOGIC_CORE -- requirements
Module: param_logic_core

---
 rtl/param_logic_pkg.sv | 17 +
 rtl/param_logic_if.sv | 33 +++
 rtl/param_logic_alu.sv | 39 +++
 rtl/param_logic_core.sv | 93 +++++++++
 4 files changed

// File: rtl/param_logic_pkg.sv
// Shared constants for the parameterised logic core: opcode encodings and
// default operand/counter widths.
package param_logic_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_CNT_WIDTH = 16;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR3  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_MUX  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

endpackage

// File: rtl/param_logic_if.sv
// Operand/result handshake bundle between a producer/consumer (master) and
// the logic core (slave).
interface param_logic_if
  import param_logic_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           op;
  logic [WIDTH-1:0]     bit_a;
  logic [WIDTH-1:0]     bit_b;
  logic [WIDTH-1:0]     bit_c;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic                 carry_out;
  logic                 op_error;
  logic [CNT_WIDTH-1:0] result_count;

  modport master (
    output in_valid, op, bit_a, bit_b, bit_c, out_ready,
    input  in_ready, out_valid, result, carry_out, op_error, result_count
  );

  modport slave (
    input  in_valid, op, bit_a, bit_b, bit_c, out_ready,
    output in_ready, out_valid, result, carry_out, op_error, result_count
  );

endinterface

// File: rtl/param_logic_alu.sv
// Combinational op evaluator sitting between the operand and result stages.
module param_logic_alu
  import param_logic_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             op_error
);

  // Only c[0] feeds the adder as a carry-in; the upper c bits are don't-care here.
  logic [WIDTH:0] sum;
  assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c[0]};

  always_comb begin
    result    = '0;
    carry_out = 1'b0;
    op_error  = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_NAND: result = ~(a & b);
      OP_OR3:  result = a | b | c;
      OP_NOR:  result = ~(a | b);
      OP_ADD: begin
        result    = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
      end
      OP_MUX:  result = (c & b) | (~c & a);
      OP_XOR:  result = a ^ b;
      default: op_error = 1'b1;
    endcase
  end

endmodule

// File: rtl/param_logic_core.sv
// Two-stage valid/ready logic core: S1 captures op and operands, S2 holds the
// evaluated result; counts every delivered result.
module param_logic_core
  import param_logic_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  param_logic_if.slave bus
);

  logic                 vld_p1;
  logic [2:0]           op_p1;
  logic [WIDTH-1:0]     a_p1, b_p1, c_p1;
  logic                 vld_p2;
  logic [WIDTH-1:0]     res_p2;
  logic                 cout_p2, err_p2;
  logic [CNT_WIDTH-1:0] cnt_p2;

  logic [WIDTH-1:0]     alu_res;
  logic                 alu_cout, alu_err;
  logic                 in_ready, in_fire, out_fire, s2_load;

  assign out_fire = vld_p2 && bus.out_ready;
  assign s2_load  = vld_p1 && (!vld_p2 || bus.out_ready);
  assign in_ready = !vld_p1 || s2_load;
  assign in_fire  = bus.in_valid && in_ready;

  // Stage 1: operand capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (in_fire) begin
      vld_p1 <= 1'b1;
    end else if (s2_load) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (in_fire) begin
      op_p1 <= bus.op;
      a_p1  <= bus.bit_a;
      b_p1  <= bus.bit_b;
      c_p1  <= bus.bit_c;
    end
  end

  param_logic_alu #(.WIDTH(WIDTH)) u_alu (
    .op        (op_p1),
    .a         (a_p1),
    .b         (b_p1),
    .c         (c_p1),
    .result    (alu_res),
    .carry_out (alu_cout),
    .op_error  (alu_err)
  );

  // Stage 2: result register; its outputs are visible, so they reset to zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      res_p2  <= '0;
      cout_p2 <= 1'b0;
      err_p2  <= 1'b0;
    end else if (s2_load) begin
      vld_p2  <= 1'b1;
      res_p2  <= alu_res;
      cout_p2 <= alu_cout;
      err_p2  <= alu_err;
    end else if (out_fire) begin
      vld_p2  <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_p2 <= '0;
    end else if (out_fire) begin
      cnt_p2 <= cnt_p2 + CNT_WIDTH'(1);
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = vld_p2;
  assign bus.result       = res_p2;
  assign bus.carry_out    = cout_p2;
  assign bus.op_error     = err_p2;
  assign bus.result_count = cnt_p2;

endmodule
